pipelined_control_unit: RTL and testbench

- Successor to the combinational control decoder, generalised to a registered ID/EX control stage.
- Decodes RV32I plus an optional M extension and registers the control bundle for the EX stage.
- Handles stall (hold), flush (bubble) and illegal/environment instructions.
- Runs a multi-cycle busy sequencer for MUL/DIV. It sits between the fetch/decode pipeline register and the ALU/datapath.

---
 rtl/ctrl_pkg.sv | 95 +++++++++
 rtl/control_decode.sv | 156 +++++++++++++++
 rtl/pipelined_control_unit.sv | 112 +++++++++++
 tb/tb_pipelined_control_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings and the registered control bundle for the ID/EX control stage.
package ctrl_pkg;

   // ALU operation codes (19 ops, fit in 5 bits)
   localparam logic [4:0] ALU_ADD    = 5'd0;
   localparam logic [4:0] ALU_SUB    = 5'd1;
   localparam logic [4:0] ALU_OR     = 5'd2;
   localparam logic [4:0] ALU_XOR    = 5'd3;
   localparam logic [4:0] ALU_AND    = 5'd4;
   localparam logic [4:0] ALU_LSL    = 5'd5;
   localparam logic [4:0] ALU_LSR    = 5'd6;
   localparam logic [4:0] ALU_ASR    = 5'd7;
   localparam logic [4:0] ALU_SLT    = 5'd8;
   localparam logic [4:0] ALU_SLTU   = 5'd9;
   localparam logic [4:0] ALU_B      = 5'd10;
   localparam logic [4:0] ALU_MUL    = 5'd11;
   localparam logic [4:0] ALU_MULH   = 5'd12;
   localparam logic [4:0] ALU_MULHSU = 5'd13;
   localparam logic [4:0] ALU_MULHU  = 5'd14;
   localparam logic [4:0] ALU_DIV    = 5'd15;
   localparam logic [4:0] ALU_DIVU   = 5'd16;
   localparam logic [4:0] ALU_REM    = 5'd17;
   localparam logic [4:0] ALU_REMU   = 5'd18;

   // Immediate formats
   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   // Next-PC select; BRANCH takes on a true ALU condition, BRANCH_INV on a false one
   localparam logic [2:0] PC_NEXT       = 3'd0;
   localparam logic [2:0] PC_JAL        = 3'd1;
   localparam logic [2:0] PC_JALR       = 3'd2;
   localparam logic [2:0] PC_BRANCH     = 3'd3;
   localparam logic [2:0] PC_BRANCH_INV = 3'd4;

   // Writeback source
   localparam logic [1:0] RES_ALU = 2'd0;
   localparam logic [1:0] RES_MEM = 2'd1;
   localparam logic [1:0] RES_PC4 = 2'd2;

   // Memory access size
   localparam logic [1:0] MEM_BYTE = 2'd0;
   localparam logic [1:0] MEM_HALF = 2'd1;
   localparam logic [1:0] MEM_WORD = 2'd2;

   // RV32 major opcodes
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [4:0] alu_ctrl;
      logic       alu_src;
      logic [2:0] imm_src;
      logic [2:0] pc_src;
      logic       reg_write;
      logic       mem_write;
      logic       mem_read;
      logic [1:0] result_src;
      logic [1:0] mem_size;
      logic       mem_unsigned;
      logic       illegal;
      logic       env;
   } ctrl_bundle_t;

   // The bundle a bubble (and reset) carries: a harmless no-op
   function automatic ctrl_bundle_t bubble_bundle();
      ctrl_bundle_t b;
      b.alu_ctrl     = ALU_ADD;
      b.alu_src      = 1'b0;
      b.imm_src      = IMM_I;
      b.pc_src       = PC_NEXT;
      b.reg_write    = 1'b0;
      b.mem_write    = 1'b0;
      b.mem_read     = 1'b0;
      b.result_src   = RES_ALU;
      b.mem_size     = MEM_WORD;
      b.mem_unsigned = 1'b0;
      b.illegal      = 1'b0;
      b.env          = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational RV32I(+M) decoder: instruction word to control bundle.
module control_decode
   import ctrl_pkg::*;
#(
   parameter bit ENABLE_M = 1'b1
) (
   input  logic [31:0]  instr_i,
   output ctrl_bundle_t ctrl_o,
   output logic         is_mul_o,
   output logic         is_div_o
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];

   // Decode opcode/funct3/funct7 into the control bundle; undefined encodings flag illegal
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      ctrl_o   = bubble_bundle();
      is_mul_o = 1'b0;
      is_div_o = 1'b0;
      unique case (opcode)
         OPC_OP: begin
            ctrl_o.reg_write = 1'b1;
            if (funct7 == 7'b0000000) begin
               unique case (funct3)
                  3'b000:  ctrl_o.alu_ctrl = ALU_ADD;
                  3'b001:  ctrl_o.alu_ctrl = ALU_LSL;
                  3'b010:  ctrl_o.alu_ctrl = ALU_SLT;
                  3'b011:  ctrl_o.alu_ctrl = ALU_SLTU;
                  3'b100:  ctrl_o.alu_ctrl = ALU_XOR;
                  3'b101:  ctrl_o.alu_ctrl = ALU_LSR;
                  3'b110:  ctrl_o.alu_ctrl = ALU_OR;
                  default: ctrl_o.alu_ctrl = ALU_AND;
               endcase
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               ctrl_o.alu_ctrl = ALU_SUB;
            end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
               ctrl_o.alu_ctrl = ALU_ASR;
            end else if (funct7 == 7'b0000001 && ENABLE_M) begin
               is_mul_o = ~funct3[2];
               is_div_o = funct3[2];
               unique case (funct3)
                  3'b000:  ctrl_o.alu_ctrl = ALU_MUL;
                  3'b001:  ctrl_o.alu_ctrl = ALU_MULH;
                  3'b010:  ctrl_o.alu_ctrl = ALU_MULHSU;
                  3'b011:  ctrl_o.alu_ctrl = ALU_MULHU;
                  3'b100:  ctrl_o.alu_ctrl = ALU_DIV;
                  3'b101:  ctrl_o.alu_ctrl = ALU_DIVU;
                  3'b110:  ctrl_o.alu_ctrl = ALU_REM;
                  default: ctrl_o.alu_ctrl = ALU_REMU;
               endcase
            end else begin
               ctrl_o.illegal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_src   = 1'b1;
            unique case (funct3)
               3'b000: ctrl_o.alu_ctrl = ALU_ADD;
               3'b010: ctrl_o.alu_ctrl = ALU_SLT;
               3'b011: ctrl_o.alu_ctrl = ALU_SLTU;
               3'b100: ctrl_o.alu_ctrl = ALU_XOR;
               3'b110: ctrl_o.alu_ctrl = ALU_OR;
               3'b111: ctrl_o.alu_ctrl = ALU_AND;
               3'b001: begin
                  ctrl_o.alu_ctrl = ALU_LSL;
                  ctrl_o.illegal  = (funct7 != 7'b0000000);
               end
               default: begin
                  ctrl_o.alu_ctrl = (funct7[5]) ? ALU_ASR : ALU_LSR;
                  ctrl_o.illegal  = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
               end
            endcase
         end
         OPC_LOAD: begin
            ctrl_o.reg_write    = 1'b1;
            ctrl_o.mem_read     = 1'b1;
            ctrl_o.alu_src      = 1'b1;
            ctrl_o.result_src   = RES_MEM;
            ctrl_o.mem_size     = funct3[1:0];
            ctrl_o.mem_unsigned = funct3[2];
            ctrl_o.illegal      = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         OPC_STORE: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.imm_src   = IMM_S;
            ctrl_o.mem_size  = funct3[1:0];
            ctrl_o.illegal   = (funct3[2] == 1'b1) || (funct3[1:0] == 2'b11);
         end
         OPC_BRANCH: begin
            ctrl_o.imm_src = IMM_B;
            ctrl_o.pc_src  = funct3[0] ? PC_BRANCH_INV : PC_BRANCH;
            unique case (funct3[2:1])
               2'b00:   ctrl_o.alu_ctrl = ALU_SUB;
               2'b10:   ctrl_o.alu_ctrl = ALU_SLT;
               2'b11:   ctrl_o.alu_ctrl = ALU_SLTU;
               default: ctrl_o.illegal  = 1'b1;
            endcase
         end
         OPC_LUI: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.imm_src   = IMM_U;
            ctrl_o.alu_ctrl  = ALU_B;
         end
         OPC_AUIPC: begin
            // Operand A comes from the PC; the datapath selects it from the opcode
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.imm_src   = IMM_U;
            ctrl_o.alu_ctrl  = ALU_ADD;
         end
         OPC_JAL: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.imm_src    = IMM_J;
            ctrl_o.pc_src     = PC_JAL;
            ctrl_o.result_src = RES_PC4;
         end
         OPC_JALR: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.alu_src    = 1'b1;
            ctrl_o.pc_src     = PC_JALR;
            ctrl_o.result_src = RES_PC4;
            ctrl_o.illegal    = (funct3 != 3'b000);
         end
         OPC_FENCE: begin
            ctrl_o.illegal = (funct3 != 3'b000);
         end
         OPC_SYSTEM: begin
            // Only ecall and ebreak are defined without Zicsr
            if (instr_i == 32'h0000_0073 || instr_i == 32'h0010_0073) ctrl_o.env = 1'b1;
            else                                                      ctrl_o.illegal = 1'b1;
         end
         default: ctrl_o.illegal = 1'b1;
      endcase

      // An undefined instruction must not touch architectural state
      if (ctrl_o.illegal) begin
         ctrl_o.reg_write = 1'b0;
         ctrl_o.mem_write = 1'b0;
         ctrl_o.mem_read  = 1'b0;
         ctrl_o.env       = 1'b0;
         is_mul_o         = 1'b0;
         is_div_o         = 1'b0;
      end
   end

endmodule

// File: rtl/pipelined_control_unit.sv
// Registered ID/EX control stage with stall/flush handling and an M-op busy sequencer.
module pipelined_control_unit
   import ctrl_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter bit ENABLE_M      = 1'b1,
   parameter int MUL_CYCLES    = 2,
   parameter int DIV_CYCLES    = 32,
   parameter int ALUCTRL_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_WIDTH-1:0]    instr,
   input  logic                     valid_in,
   input  logic                     stall,
   input  logic                     flush,
   output logic                     valid_out,
   output logic [ALUCTRL_WIDTH-1:0] ALUctrl,
   output logic                     ALUsrc,
   output logic [2:0]               ImmSrc,
   output logic [2:0]               PCsrc,
   output logic                     RegWrite,
   output logic                     MemWrite,
   output logic                     MemRead,
   output logic [1:0]               ResultSrc,
   output logic [1:0]               MemSize,
   output logic                     MemUnsigned,
   output logic                     muldiv_start,
   output logic                     busy,
   output logic                     illegal,
   output logic                     env
);

   localparam int CNT_W = $clog2(DIV_CYCLES + 1);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

   typedef enum logic {S_IDLE, S_MULDIV} state_e;

   ctrl_bundle_t     dec_bundle;
   logic             dec_is_mul;
   logic             dec_is_div;
   logic [CNT_W-1:0] m_load;

   ctrl_bundle_t     bundle_q;
   logic             valid_q;
   logic             start_q;
   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;

   control_decode #(.ENABLE_M(ENABLE_M)) u_decode (
      .instr_i  (instr[31:0]),
      .ctrl_o   (dec_bundle),
      .is_mul_o (dec_is_mul),
      .is_div_o (dec_is_div)
   );

   // Remaining busy cycles after the load edge for the incoming M op
   assign m_load = dec_is_div ? DIV_LOAD : MUL_LOAD;

   // Pipeline register, FSM and counter with priority rst > flush > busy > stall > load
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      start_q <= 1'b0;
      if (rst) begin
         bundle_q <= bubble_bundle();
         valid_q  <= 1'b0;
         state_q  <= S_IDLE;
         cnt_q    <= '0;
      end else if (flush) begin
         bundle_q <= bubble_bundle();
         valid_q  <= 1'b0;
         state_q  <= S_IDLE;
         cnt_q    <= '0;
      end else if (state_q == S_MULDIV) begin
         if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
         if (cnt_q <= CNT_W'(1)) state_q <= S_IDLE;
      end else if (stall) begin
         // hold the registered bundle
      end else if (valid_in) begin
         bundle_q <= dec_bundle;
         valid_q  <= 1'b1;
         if (dec_is_mul || dec_is_div) begin
            start_q <= 1'b1;
            if (m_load != '0) begin
               state_q <= S_MULDIV;
               cnt_q   <= m_load;
            end
         end
      end else begin
         bundle_q <= bubble_bundle();
         valid_q  <= 1'b0;
      end
   end

   assign busy         = (cnt_q != '0);
   assign valid_out    = valid_q;
   assign muldiv_start = start_q;
   assign ALUctrl      = ALUCTRL_WIDTH'(bundle_q.alu_ctrl);
   assign ALUsrc       = bundle_q.alu_src;
   assign ImmSrc       = bundle_q.imm_src;
   assign PCsrc        = bundle_q.pc_src;
   assign RegWrite     = bundle_q.reg_write;
   assign MemWrite     = bundle_q.mem_write;
   assign MemRead      = bundle_q.mem_read;
   assign ResultSrc    = bundle_q.result_src;
   assign MemSize      = bundle_q.mem_size;
   assign MemUnsigned  = bundle_q.mem_unsigned;
   assign illegal      = bundle_q.illegal;
   assign env          = bundle_q.env;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed self-checking bench for pipelined_control_unit (default M-enabled and M-disabled instances).
module tb_pipelined_control_unit;

   logic        clk = 1'b0;
   logic        rst, valid_in, stall, flush;
   logic [31:0] instr;

   logic       valid_out, ALUsrc, RegWrite, MemWrite, MemRead, MemUnsigned;
   logic       muldiv_start, busy, illegal, env;
   logic [4:0] ALUctrl;
   logic [2:0] ImmSrc, PCsrc;
   logic [1:0] ResultSrc, MemSize;

   logic       nm_valid_out, nm_ALUsrc, nm_RegWrite, nm_MemWrite, nm_MemRead, nm_MemUnsigned;
   logic       nm_muldiv_start, nm_busy, nm_illegal, nm_env;
   logic [4:0] nm_ALUctrl;
   logic [2:0] nm_ImmSrc, nm_PCsrc;
   logic [1:0] nm_ResultSrc, nm_MemSize;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   pipelined_control_unit dut (
      .clk(clk), .rst(rst), .instr(instr), .valid_in(valid_in), .stall(stall), .flush(flush),
      .valid_out(valid_out), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmSrc(ImmSrc), .PCsrc(PCsrc),
      .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead), .ResultSrc(ResultSrc),
      .MemSize(MemSize), .MemUnsigned(MemUnsigned), .muldiv_start(muldiv_start), .busy(busy),
      .illegal(illegal), .env(env)
   );

   pipelined_control_unit #(.ENABLE_M(1'b0)) dut_nm (
      .clk(clk), .rst(rst), .instr(instr), .valid_in(valid_in), .stall(stall), .flush(flush),
      .valid_out(nm_valid_out), .ALUctrl(nm_ALUctrl), .ALUsrc(nm_ALUsrc), .ImmSrc(nm_ImmSrc),
      .PCsrc(nm_PCsrc), .RegWrite(nm_RegWrite), .MemWrite(nm_MemWrite), .MemRead(nm_MemRead),
      .ResultSrc(nm_ResultSrc), .MemSize(nm_MemSize), .MemUnsigned(nm_MemUnsigned),
      .muldiv_start(nm_muldiv_start), .busy(nm_busy), .illegal(nm_illegal), .env(nm_env)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_SUB   = 32'h402081B3;
   localparam logic [31:0] I_SB    = 32'h00110023;
   localparam logic [31:0] I_BNE   = 32'h00209063;
   localparam logic [31:0] I_BLTU  = 32'h0020E063;
   localparam logic [31:0] I_LW    = 32'h0000A283;
   localparam logic [31:0] I_LHU   = 32'h0000D283;
   localparam logic [31:0] I_JAL   = 32'h000000EF;
   localparam logic [31:0] I_DIV   = 32'h027342B3;
   localparam logic [31:0] I_MUL   = 32'h023100B3;
   localparam logic [31:0] I_ILL   = 32'h0000007F;
   localparam logic [31:0] I_ECALL = 32'h00000073;

   initial begin
      int busy_cnt, held, starts;
      rst = 1'b1; instr = I_ADD; valid_in = 1'b1; stall = 1'b0; flush = 1'b0;
      #2;

      // Reset held two cycles
      tick(); tick();
      check("rst valid_out", valid_out, 0);
      check("rst RegWrite", RegWrite, 0);
      check("rst busy", busy, 0);
      check("rst ALUctrl", ALUctrl, 0);
      check("rst PCsrc", PCsrc, 0);
      check("rst MemSize", MemSize, 2);
      check("rst muldiv_start", muldiv_start, 0);
      rst = 1'b0;

      // add, then sb
      tick();
      check("add valid_out", valid_out, 1);
      check("add RegWrite", RegWrite, 1);
      check("add ALUsrc", ALUsrc, 0);
      check("add ALUctrl", ALUctrl, 0);
      instr = I_SB; tick();
      check("sb MemWrite", MemWrite, 1);
      check("sb ALUsrc", ALUsrc, 1);
      check("sb MemSize", MemSize, 0);
      check("sb RegWrite", RegWrite, 0);
      check("sb ImmSrc", ImmSrc, 1);

      // sub, bne, bltu, jal, lhu
      instr = I_SUB; tick();
      check("sub ALUctrl", ALUctrl, 1);
      instr = I_BNE; tick();
      check("bne ALUctrl", ALUctrl, 1);
      check("bne PCsrc", PCsrc, 4);
      check("bne RegWrite", RegWrite, 0);
      instr = I_BLTU; tick();
      check("bltu ALUctrl", ALUctrl, 9);
      check("bltu PCsrc", PCsrc, 3);
      instr = I_JAL; tick();
      check("jal PCsrc", PCsrc, 1);
      check("jal ResultSrc", ResultSrc, 2);
      check("jal ImmSrc", ImmSrc, 4);
      instr = I_LHU; tick();
      check("lhu MemSize", MemSize, 1);
      check("lhu MemUnsigned", MemUnsigned, 1);

      // div: 1-cycle start pulse, 31 busy cycles, bundle held 32 cycles; stall mid-busy is ignored
      instr = I_DIV; tick();
      check("div ALUctrl", ALUctrl, 15);
      check("div start", muldiv_start, 1);
      check("div busy first", busy, 1);
      instr = I_ADD;
      busy_cnt = 1; held = 1; starts = 0;
      for (int k = 1; k <= 40; k++) begin
         stall = (k >= 3 && k <= 6);
         tick();
         if (ALUctrl != 5'd15) break;
         held++;
         if (busy) busy_cnt++;
         if (muldiv_start) starts++;
      end
      stall = 1'b0;
      check("div busy cycles", busy_cnt, 31);
      check("div held cycles", held, 32);
      check("div extra starts", starts, 0);
      check("after div add ALUctrl", ALUctrl, 0);
      check("after div add valid", valid_out, 1);

      // div aborted by flush on the 5th busy cycle
      instr = I_DIV; tick();
      check("div2 busy", busy, 1);
      instr = I_ADD;
      tick(); tick(); tick(); tick();
      check("div2 busy cycle5", busy, 1);
      flush = 1'b1; tick(); flush = 1'b0;
      check("flush valid_out", valid_out, 0);
      check("flush busy", busy, 0);
      check("flush ALUctrl", ALUctrl, 0);
      tick();
      check("post-flush add valid", valid_out, 1);
      check("post-flush add RegWrite", RegWrite, 1);
      check("post-flush busy", busy, 0);

      // lw held by stall for 3 cycles, then flush with stall gives a bubble
      instr = I_LW; tick();
      check("lw MemRead", MemRead, 1);
      check("lw ResultSrc", ResultSrc, 1);
      instr = I_ADD; stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("stall MemRead", MemRead, 1);
         check("stall ResultSrc", ResultSrc, 1);
         check("stall valid_out", valid_out, 1);
      end
      flush = 1'b1; tick(); flush = 1'b0; stall = 1'b0;
      check("flush+stall valid_out", valid_out, 0);
      check("flush+stall MemRead", MemRead, 0);

      // illegal opcode, then ecall
      instr = I_ILL; tick();
      check("ill illegal", illegal, 1);
      check("ill valid_out", valid_out, 1);
      check("ill enables", {RegWrite, MemWrite, MemRead}, 0);
      instr = I_ECALL; tick();
      check("ecall env", env, 1);
      check("ecall RegWrite", RegWrite, 0);
      check("ecall illegal", illegal, 0);

      // mul: N=2 gives one busy cycle; M-disabled instance flags it illegal
      instr = I_MUL; tick();
      check("mul ALUctrl", ALUctrl, 11);
      check("mul start", muldiv_start, 1);
      check("mul busy", busy, 1);
      check("nm mul illegal", nm_illegal, 1);
      check("nm mul busy", nm_busy, 0);
      check("nm mul start", nm_muldiv_start, 0);
      check("nm mul RegWrite", nm_RegWrite, 0);
      instr = I_ADD; tick();
      check("mul held", ALUctrl, 11);
      check("mul busy end", busy, 0);
      check("mul start end", muldiv_start, 0);
      tick();
      check("after mul add", RegWrite, 1);
      check("after mul illegal", illegal, 0);

      // no valid input gives a bubble
      valid_in = 1'b0; tick();
      check("bubble valid_out", valid_out, 0);
      check("bubble RegWrite", RegWrite, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
